// File: rtl/i4003_chain_loader.sv
// Drives cp, serial data and enable for a chain of i4003 shift registers, one bit per cp pulse, MSB first.
// Latency: cp rises on the accept edge; done pulses WIDTH*(CP_HI_CYC+CP_LO_CYC) cycles after that edge.
// Backpressure: load_ready is low for the whole frame; a word offered while busy waits for the done cycle.
module i4003_chain_loader #(
    parameter int WIDTH              = 20,
    parameter int CP_HI_CYC          = 120,
    parameter int DATA_DLY_CYC       = 5,
    parameter int DATA_WID_CYC       = 55,
    parameter int CP_LO_CYC          = 120,
    parameter int BLANK_DURING_SHIFT = 1
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             busy,
    output logic             done,
    output logic             cp,
    output logic             serial_out,
    output logic             enable
);
    localparam int HOLD_CYC = CP_HI_CYC - DATA_DLY_CYC - DATA_WID_CYC;
    localparam int CW       = $clog2(CP_HI_CYC + CP_LO_CYC + 1);
    localparam int BW       = $clog2(WIDTH + 1);

    if (CP_HI_CYC < 1 || DATA_DLY_CYC < 1 || DATA_WID_CYC < 1 || CP_LO_CYC < 1) begin : g_bad_cycle_param
        $error("i4003_chain_loader: all cycle parameters must be >= 1");
    end
    if (DATA_DLY_CYC + DATA_WID_CYC >= CP_HI_CYC) begin : g_bad_data_window
        $error("i4003_chain_loader: DATA_DLY_CYC + DATA_WID_CYC must be < CP_HI_CYC");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DATA, S_HOLD, S_LOW} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cyc_cnt, cyc_reload;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             last_cyc, xfer;
    logic             cp_nxt, ser_nxt, done_nxt, en_nxt;

    assign last_cyc   = (cyc_cnt == '0);
    assign xfer       = (state == S_IDLE) && load_valid;
    assign load_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_valid) state_nxt = S_SETUP;
            S_SETUP: if (last_cyc)   state_nxt = S_DATA;
            S_DATA:  if (last_cyc)   state_nxt = S_HOLD;
            S_HOLD:  if (last_cyc)   state_nxt = S_LOW;
            S_LOW:   if (last_cyc)   state_nxt = (bit_cnt == '0) ? S_IDLE : S_SETUP;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // The counter is loaded with (duration - 1) on every state entry and counts down to zero.
    always_comb begin
        cyc_reload = '0;
        case (state_nxt)
            S_SETUP: cyc_reload = CW'(DATA_DLY_CYC - 1);
            S_DATA:  cyc_reload = CW'(DATA_WID_CYC - 1);
            S_HOLD:  cyc_reload = CW'(HOLD_CYC - 1);
            S_LOW:   cyc_reload = CW'(CP_LO_CYC - 1);
            default: cyc_reload = '0;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (state != state_nxt) begin
                cyc_cnt <= cyc_reload;
            end else if (cyc_cnt != '0) begin
                cyc_cnt <= cyc_cnt - 1'b1;
            end

            if (xfer) begin
                shreg   <= load_data;
                bit_cnt <= BW'(WIDTH - 1);
            end else if (state == S_LOW && last_cyc && bit_cnt != '0) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state they belong to.
    always_comb begin
        cp_nxt   = (state_nxt == S_SETUP) || (state_nxt == S_DATA) || (state_nxt == S_HOLD);
        ser_nxt  = (state_nxt == S_DATA) && shreg[WIDTH-1];
        done_nxt = (state == S_LOW) && (state_nxt == S_IDLE);
        en_nxt   = enable;
        if (done_nxt) begin
            en_nxt = 1'b1;
        end else if (xfer && BLANK_DURING_SHIFT != 0) begin
            en_nxt = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cp         <= 1'b0;
            serial_out <= 1'b0;
            done       <= 1'b0;
            enable     <= 1'b0;
        end else begin
            cp         <= cp_nxt;
            serial_out <= ser_nxt;
            done       <= done_nxt;
            enable     <= en_nxt;
        end
    end
endmodule
